ice_button_conditioner: RTL and testbench
=========================================

Name: ice_button_conditioner

Overview:
Parametrised N-channel front end for raw board buttons on the iCEstick stopwatch top. Replaces ad-hoc wiring of button pins straight into the stopwatch core.
- Each channel: polarity normalisation, 2-FF synchroniser, tick-based debouncing.
- Outputs per channel: clean level, single-cycle press/release pulses, optional long-press pulse.
- Sits between the board pins and the clock divider / stopwatch core, in the 12 MHz domain.

Parameters:
N_CH, 3, number of button channels.
TICK_DIV, 12000, clk_in cycles per debounce sample tick (1 ms at 12 MHz); must be >= 1.
DEB_TICKS, 5, consecutive differing ticks needed to accept a new level; must be >= 1.
LONG_TICKS, 1000, ticks of continuous press before o_long fires; 0 disables long-press.
ACTIVE_LOW_MASK, {N_CH{1'b0}}, bit i = 1 means raw input i is active-low.

Ports:
clk_in  input  1  system clock, 12 MHz board clock
res  input  1  synchronous active-high reset
i_raw  input  N_CH  raw asynchronous button pins
o_level  output  N_CH  debounced level, 1 = pressed
o_press  output  N_CH  one-cycle pulse on an accepted 0->1 transition
o_release  output  N_CH  one-cycle pulse on an accepted 1->0 transition
o_long  output  N_CH  one-cycle pulse when a press has been held LONG_TICKS ticks
o_any_active  output  1  OR of o_level
o_tick  output  1  shared sample tick, for observability

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high on res. All state updates on the rising edge of clk_in.
- Reset values: every output 0. Synchroniser FFs, prescaler, debounce counters and hold counters all 0.
- Normalisation: n[i] = i_raw[i] XOR ACTIVE_LOW_MASK[i], followed by a 2-FF synchroniser giving s[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - o_tick = 1 for exactly the one cycle where count == TICK_DIV-1.
  - TICK_DIV = 1 means a tick every cycle.
- Debounce, per channel, evaluated only on tick cycles (stable level L, counter c):
  - If s == L: c <= 0.
  - Else if c == DEB_TICKS-1: L <= s and c <= 0.
  - Else: c <= c+1.
  - Counter width: clog2(DEB_TICKS+1).
- Outputs from the debounced level:
  - o_level = L, registered.
  - o_press[i] = 1 in exactly the cycle in which o_level[i] first reads 1.
  - o_release[i] = 1 in exactly the cycle in which o_level[i] first reads 0.
- Latency: raw edge to o_level change takes 2 cycles of synchroniser plus DEB_TICKS ticks, with the first tick falling anywhere in the following TICK_DIV cycles.
- Glitch rejection: any sample equal to L during the count clears c, so a pulse shorter than DEB_TICKS ticks is never accepted.
- Long-press, per channel, with hold counter h:
  - While L == 1, h increments on each tick and saturates at LONG_TICKS.
  - o_long pulses for one cycle on the tick where h becomes LONG_TICKS. It fires at most once per press.
  - h clears when L == 0.
  - If LONG_TICKS == 0, o_long stays 0 and h is not built.
- Simultaneous events:
  - Channels are fully independent; any combination of pulses may be asserted in one cycle.
  - o_press and o_release are never both high on the same channel in the same cycle.
- Reset mid-operation: all state clears immediately and no pulse is emitted on the reset edge.
  - A button held through reset reads as released (L = 0).
  - After res deasserts, it produces o_press once DEB_TICKS ticks have elapsed.
- o_any_active is a registered OR of o_level, asserted in the same cycle as o_level.

Decomposition:
- Shared package ice_pkg: the clog2 function, default TICK_DIV for 12 MHz, and default channel indices.
  - CH_START_STOP = 0, CH_LAP = 1, CH_RESET = 2, matching the stopwatch ui_in bit order.
- One sub-module, btn_channel. It holds the sync chain, debounce counter, hold counter and pulse logic for one channel, and takes the tick as an input.
- The top instantiates the prescaler and a generate loop of N_CH btn_channel instances.

Test Plan:
Common bench configuration: N_CH=3, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=5, ACTIVE_LOW_MASK=3'b001.
- Reset/idle: res high 3 cycles, then i_raw = 3'b001 (all released) -> all outputs 0 for 100 cycles; o_tick fires every 4th cycle.
- Clean press on channel 1: i_raw[1] goes 0->1 and holds -> o_level[1] rises 2 sync cycles plus 3 ticks later (within 2+12+4 cycles). o_press[1] is high for exactly 1 cycle; o_any_active = 1.
- Glitch rejection on channel 2: i_raw[2] high for 2 ticks (8 cycles), then low -> o_level, o_press and o_release all stay 0.
- Long press on active-low channel 0: i_raw[0] = 0 held for 12 ticks -> o_press[0] once, then o_long[0] exactly once, 5 ticks after o_level rises. Release -> o_release[0] once, with no second o_long.
- Simultaneous press on channels 1 and 2 in the same cycle -> o_press = 3'b110 in a single cycle.
- Reset mid-press: channel 1 held and o_level[1] = 1, then res pulses 1 cycle -> o_level[1] = 0 with no o_release. Channel 1 still held -> o_press[1] fires again after 3 ticks.

Source files
------------

// File: rtl/ice_button_conditioner_pkg.sv
// Shared constants and helpers for the button conditioner and the stopwatch top.
package ice_pkg;

    localparam int TICK_DIV_12MHZ = 12000;

    // Channel order matches the stopwatch ui_in bit order.
    localparam int CH_START_STOP = 0;
    localparam int CH_LAP        = 1;
    localparam int CH_RESET      = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ice_button_conditioner_if.sv
// Signal bundle around the button conditioner: board side drives pins, conditioner drives events.
interface ice_button_conditioner_if #(
    parameter int N_CH = 3
) (
    input logic clk_in
);
    logic            res;
    logic [N_CH-1:0] i_raw;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_long;
    logic            o_any_active;
    logic            o_tick;

    modport master (
        input  clk_in,
        output res, i_raw,
        input  o_level, o_press, o_release, o_long, o_any_active, o_tick
    );

    modport slave (
        input  clk_in,
        input  res, i_raw,
        output o_level, o_press, o_release, o_long, o_any_active, o_tick
    );
endinterface

// File: rtl/ice_button_conditioner_btn_channel.sv
// One button channel: polarity fix, 2-FF synchroniser, tick-sampled debounce, edge and long-press pulses.
module btn_channel
    import ice_pkg::*;
#(
    parameter int DEB_TICKS  = 5,
    parameter int LONG_TICKS = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk_in,
    input  logic res,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int            CW       = clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] deb_q, deb_d;
    logic          press_q, release_q;

    // NOTE: every variable gets a default before the branches, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        deb_d   = deb_q;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                deb_d = '0;
            end else if (deb_q == DEB_LAST) begin
                level_d = sync2_q;
                deb_d   = '0;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (res) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i ^ ACTIVE_LOW;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_q     <= deb_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    generate
        if (LONG_TICKS > 0) begin : g_long
            localparam int            HW       = clog2(LONG_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

            logic [HW-1:0] hold_q;
            logic          long_q;

            // Hold count saturates, so the pulse can fire only once per press.
            always_ff @(posedge clk_in) begin
                if (res) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (!level_q) begin
                        hold_q <= '0;
                    end else if (tick_i && hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + 1'b1;
                        long_q <= (hold_q == HOLD_MAX - 1'b1);
                    end
                end
            end

            assign long_o = long_q;
        end else begin : g_no_long
            assign long_o = 1'b0;
        end
    endgenerate

    assign level_o   = level_q;
    assign level_d_o = level_d;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/ice_button_conditioner.sv
// N-channel button front end: shared sample-tick prescaler feeding one btn_channel per button.
module ice_button_conditioner
    import ice_pkg::*;
#(
    parameter int              N_CH            = 3,
    parameter int              TICK_DIV        = TICK_DIV_12MHZ,
    parameter int              DEB_TICKS       = 5,
    parameter int              LONG_TICKS      = 1000,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic            clk_in,
    input  logic            res,
    input  logic [N_CH-1:0] i_raw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic            o_any_active,
    output logic            o_tick
);
    localparam int            PW       = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   pre_q;
    logic [N_CH-1:0] level_d;
    logic            any_q;

    assign o_tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk_in) begin
        if (res) begin
            pre_q <= '0;
            any_q <= 1'b0;
        end else begin
            pre_q <= o_tick ? '0 : pre_q + 1'b1;
            // Built from next-state levels so it lines up with o_level.
            any_q <= |level_d;
        end
    end

    assign o_any_active = any_q;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            btn_channel #(
                .DEB_TICKS  (DEB_TICKS),
                .LONG_TICKS (LONG_TICKS),
                .ACTIVE_LOW (ACTIVE_LOW_MASK[i])
            ) u_ch (
                .clk_in    (clk_in),
                .res       (res),
                .tick_i    (o_tick),
                .raw_i     (i_raw[i]),
                .level_o   (o_level[i]),
                .level_d_o (level_d[i]),
                .press_o   (o_press[i]),
                .release_o (o_release[i]),
                .long_o    (o_long[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ice_button_conditioner.sv
// Directed plus randomized bench for ice_button_conditioner against a tick-level behavioural model.
module tb_ice_button_conditioner;
    localparam int         N    = 3;
    localparam int         TD   = 4;
    localparam int         DEB  = 3;
    localparam int         LONG = 5;
    localparam logic [2:0] MASK = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ice_button_conditioner_if #(.N_CH(N)) bif (.clk_in(clk));

    ice_button_conditioner #(
        .N_CH            (N),
        .TICK_DIV        (TD),
        .DEB_TICKS       (DEB),
        .LONG_TICKS      (LONG),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk_in       (clk),
        .res          (bif.res),
        .i_raw        (bif.i_raw),
        .o_level      (bif.o_level),
        .o_press      (bif.o_press),
        .o_release    (bif.o_release),
        .o_long       (bif.o_long),
        .o_any_active (bif.o_any_active),
        .o_tick       (bif.o_tick)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: prescale phase, two-stage delay of normalised pins, and per-channel
    // run length of disagreeing tick samples plus ticks held since the press was accepted.
    int         m_phase;
    logic [2:0] m_d1, m_d2, m_lvl, m_press, m_rel, m_long;
    logic       m_any;
    int         m_run [N];
    int         m_held[N];

    int press_cnt[N], rel_cnt[N], long_cnt[N], lvl_hi_cnt[N];
    int tick_cnt, press_cyc0, long_cyc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic       tick;
        logic [2:0] samp, lvl_old;
        if (bif.res) begin
            m_phase = 0;
            m_d1 = '0; m_d2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
        end else begin
            tick    = (m_phase == TD - 1);
            m_phase = (m_phase + 1) % TD;
            samp    = m_d2;
            m_d2    = m_d1;
            m_d1    = bif.i_raw ^ MASK;
            lvl_old = m_lvl;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < N; c++) begin
                if (tick) begin
                    m_run[c] = (samp[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                    if (m_run[c] == DEB) begin
                        m_lvl[c] = samp[c];
                        m_run[c] = 0;
                        if (samp[c]) m_press[c] = 1'b1;
                        else         m_rel[c]   = 1'b1;
                    end
                end
                if (!lvl_old[c]) begin
                    m_held[c] = 0;
                end else if (tick && m_held[c] < LONG) begin
                    m_held[c]++;
                    if (m_held[c] == LONG) m_long[c] = 1'b1;
                end
            end
            m_any = |m_lvl;
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0; lvl_hi_cnt[c] = 0;
        end
        tick_cnt = 0; press_cyc0 = -1; long_cyc0 = -1;
    endtask

    // One clock: update the model on the edge, compare every output on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check("level",   32'(bif.o_level),      32'(m_lvl));
        check("press",   32'(bif.o_press),      32'(m_press));
        check("release", 32'(bif.o_release),    32'(m_rel));
        check("long",    32'(bif.o_long),       32'(m_long));
        check("any",     32'(bif.o_any_active), 32'(m_any));
        check("tick",    32'(bif.o_tick),       32'(m_phase == TD - 1));
        for (int c = 0; c < N; c++) begin
            if (bif.o_press[c] === 1'b1)   press_cnt[c]++;
            if (bif.o_release[c] === 1'b1) rel_cnt[c]++;
            if (bif.o_long[c] === 1'b1)    long_cnt[c]++;
            if (bif.o_level[c] === 1'b1)   lvl_hi_cnt[c]++;
        end
        if (bif.o_tick === 1'b1)       tick_cnt++;
        if (bif.o_press[0] === 1'b1)   press_cyc0 = cyc;
        if (bif.o_long[0] === 1'b1)    long_cyc0  = cyc;
    endtask

    task automatic wait_level(input int ch, input logic val, input int max_cyc, output int waited);
        waited = 0;
        while (bif.o_level[ch] !== val && waited < max_cyc) begin
            step();
            waited++;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset and idle.
        bif.res   = 1'b1;
        bif.i_raw = 3'b000;
        repeat (3) step();
        check("reset_level", 32'(bif.o_level), 32'd0);
        bif.res   = 1'b0;
        bif.i_raw = 3'b001;
        clear_counts();
        repeat (100) step();
        check("idle_ticks", 32'(tick_cnt), 32'd25);
        check("idle_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2]), 32'd0);
        check("idle_level", 32'(lvl_hi_cnt[0] + lvl_hi_cnt[1] + lvl_hi_cnt[2]), 32'd0);

        // Clean press on channel 1.
        clear_counts();
        bif.i_raw = 3'b011;
        wait_level(1, 1'b1, 30, n);
        check("press1_latency", 32'(n >= 10 && n <= 18), 32'd1);
        repeat (3) step();
        check("press1_count", 32'(press_cnt[1]), 32'd1);
        check("press1_any",   32'(bif.o_any_active), 32'd1);
        bif.i_raw = 3'b001;
        repeat (30) step();
        check("release1_count", 32'(rel_cnt[1]), 32'd1);

        // Glitch of two ticks on channel 2.
        clear_counts();
        bif.i_raw = 3'b101;
        repeat (8) step();
        bif.i_raw = 3'b001;
        repeat (30) step();
        check("glitch_level",   32'(lvl_hi_cnt[2]), 32'd0);
        check("glitch_press",   32'(press_cnt[2]),  32'd0);
        check("glitch_release", 32'(rel_cnt[2]),    32'd0);

        // Long press on active-low channel 0.
        clear_counts();
        bif.i_raw = 3'b000;
        repeat (48) step();
        bif.i_raw = 3'b001;
        repeat (40) step();
        check("long0_press",   32'(press_cnt[0]), 32'd1);
        check("long0_count",   32'(long_cnt[0]),  32'd1);
        check("long0_delay",   32'(long_cyc0 - press_cyc0), 32'(LONG * TD));
        check("long0_release", 32'(rel_cnt[0]),   32'd1);

        // Simultaneous press on channels 1 and 2.
        clear_counts();
        bif.i_raw = 3'b111;
        n = 0;
        while (bif.o_press === 3'b000 && n < 30) begin
            step();
            n++;
        end
        check("simul_press", 32'(bif.o_press), 32'b110);
        repeat (20) step();
        check("simul_count1", 32'(press_cnt[1]), 32'd1);
        check("simul_count2", 32'(press_cnt[2]), 32'd1);
        bif.i_raw = 3'b001;
        repeat (30) step();

        // Reset while channel 1 is held.
        bif.i_raw = 3'b011;
        wait_level(1, 1'b1, 30, n);
        check("rst_pre_level", 32'(bif.o_level[1]), 32'd1);
        clear_counts();
        bif.res = 1'b1;
        step();
        bif.res = 1'b0;
        check("rst_level",   32'(bif.o_level[1]), 32'd0);
        check("rst_release", 32'(rel_cnt[1]),     32'd0);
        n = 0;
        while (bif.o_press[1] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("rst_repress", 32'(bif.o_press[1]), 32'd1);
        check("rst_latency", 32'(n <= 18), 32'd1);
        bif.i_raw = 3'b001;
        repeat (30) step();

        // Randomized pin activity with occasional resets.
        for (int seg = 0; seg < 30; seg++) begin
            bif.i_raw = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                bif.res = 1'b1;
                step();
                bif.res = 1'b0;
            end
            repeat ($urandom_range(1, 40)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
